serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver. It sits directly downstream of the shift-register stage and consumes its serial `shiftout` bit stream.
- Detects a start bit, collects DATA_WIDTH data bits in the configured bit order, checks optional parity and the stop bit, then presents the word with a one-cycle valid pulse.
- Uses the same enable-gated bit timing and clear priority as the shift-register stage, so the two blocks chain on a common `enable` strobe.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>=2).
- SHIFT_DIRECTION, "LEFT", "LEFT" = MSB received first; "RIGHT" = LSB received first.
- PARITY, "NONE", one of "NONE", "EVEN", "ODD"; selects whether a parity bit follows the data bits.

Ports:
- clock  input  1  rising-edge clock.
- aclr  input  1  asynchronous active-high reset.
- sclr  input  1  synchronous clear; priority below aclr, above all else.
- enable  input  1  bit strobe; serial_in is sampled only on clock edges where enable=1.
- serial_in  input  1  serial line (the upstream shiftout); idles at 1.
- data_out  output  DATA_WIDTH  last good-stop-bit frame payload; held between frames.
- data_valid  output  1  one-clock pulse when data_out updates.
- parity_err  output  1  one-clock pulse, coincident with data_valid, when parity mismatches.
- frame_err  output  1  one-clock pulse when the stop bit samples 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (aclr=1, or sclr=1 at an edge): state=IDLE, bit counter=0, internal shift register=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0. aclr takes effect immediately and is independent of clock. A reset mid-frame abandons the frame with no pulse.
- Pulses: data_valid, parity_err and frame_err are registered, high for exactly one clock, and deassert on the next edge regardless of enable.
- enable=0: state, counter and shift register hold.
- FSM (transitions only on enable=1 edges):
  - IDLE: serial_in=0 -> DATA, counter=0. serial_in=1 -> stay.
  - DATA: shift in serial_in.
    - LEFT: sr <= {sr[W-2:0], serial_in}.
    - RIGHT: sr <= {serial_in, sr[W-1:1]}.
    - Counter increments on each bit. On bit index W-1: go to PARITY if PARITY != "NONE", else STOP.
  - PARITY: latch the parity bit.
    - EVEN: error if XOR(data bits, parity bit) = 1.
    - ODD: error if XOR(data bits, parity bit) = 0.
    - Then go to STOP.
  - STOP, serial_in=1: data_out <= sr (with the bit just shifted); data_valid=1; parity_err=latched error; go to IDLE.
  - STOP, serial_in=0: frame_err=1; data_out unchanged; data_valid=0; parity_err=0; go to IDLE.
- Latency: data_valid rises at the clock edge that samples the stop bit. data_out is valid in that same cycle.
- Back-to-back frames: a start bit may arrive on the very next enable edge after STOP; no idle gap is required.
- Bit sampling: no oversampling and no glitch filtering; a single sample per enable edge decides each bit.
- Counter width: $clog2(DATA_WIDTH) bits; it never wraps past W-1.
- busy goes high on the edge that accepts the start bit and low on the stop-bit edge.
- Simultaneous events: sclr=1 with enable=1 -> clear wins and no bit is consumed. aclr overrides everything.

Test Plan:
- W=8, LEFT, NONE, enable=1 every cycle; serial_in = 0,1,0,1,0,0,1,0,1,1 -> data_out=0xA5, single data_valid pulse on the 10th edge, busy high for 9 cycles, no errors.
- W=8, RIGHT, NONE; serial_in = 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first) -> data_out=0xA5. Repeat with LEFT order bits on the same config -> data_out=0xA5 bit-reversed = 0xA5 (palindrome); then send 0x01 LSB-first (0,1,0,0,0,0,0,0,0,1) -> data_out=0x01.
- W=8, LEFT, EVEN; frame 0xA5 with parity 0, stop 1 -> data_valid=1, parity_err=0. Same frame with parity 1 -> data_valid=1, parity_err=1 in the same cycle, data_out=0xA5.
- Stop bit = 0 after data 0x3C, with prior data_out=0xA5 -> frame_err pulse, no data_valid, data_out stays 0xA5, next edge state=IDLE.
- enable toggling 1,0,0,1,... across a 0x5A frame -> same result as continuous enable. Pulses still last exactly one clock even when enable=0 on the following edge.
- aclr asserted mid-DATA after 4 bits (asynchronously, between edges) -> all outputs 0 immediately. After release, a full 0x81 frame is received correctly. Repeat using sclr -> clear at the next edge, and enable=1 in that cycle is ignored.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, DATA_WIDTH data bits, optional parity, stop bit.
// Every bit advance is gated by the shared enable strobe; sclr is synchronous, aclr asynchronous.
module serial_frame_rx #(
  parameter int    DATA_WIDTH      = 8,
  parameter string SHIFT_DIRECTION = "LEFT",
  parameter string PARITY          = "NONE"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  enable,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int              CW         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam bit              LSB_FIRST  = (SHIFT_DIRECTION == "RIGHT");
  localparam bit              HAS_PARITY = (PARITY != "NONE");
  localparam bit              ODD_PARITY = (PARITY == "ODD");
  localparam logic [CW-1:0]   LAST_BIT   = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [DATA_WIDTH-1:0] sr, sr_d, data_d;
  logic                  perr, perr_d;
  logic                  valid_d, perr_out_d, ferr_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sr_d       = sr;
    perr_d     = perr;
    data_d     = data_out;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    if (enable) begin
      unique case (state)
        S_IDLE: begin
          if (!serial_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        S_DATA: begin
          if (LSB_FIRST) sr_d = {serial_in, sr[DATA_WIDTH-1:1]};
          else           sr_d = {sr[DATA_WIDTH-2:0], serial_in};
          if (cnt == LAST_BIT) begin
            cnt_d   = '0;
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_PARITY: begin
          // Even: data^parity must be 0; odd: it must be 1.
          perr_d  = (^sr) ^ serial_in ^ ODD_PARITY;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (serial_in) begin
            data_d     = sr;
            valid_d    = 1'b1;
            perr_out_d = perr;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (sclr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sr         <= sr_d;
      perr       <= perr_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      parity_err <= perr_out_d;
      frame_err  <= ferr_d;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: four instances (LEFT/NONE, RIGHT/NONE, LEFT/EVEN, RIGHT/ODD) fed one at a
// time; a scoreboard queue holds the expected result of every frame until the DUT pulses.
module tb_serial_frame_rx;

  logic       clock = 1'b0;
  logic       aclr  = 1'b1;
  logic       sclr  = 1'b0;
  logic       enable = 1'b0;
  logic       sin  [4];
  logic [7:0] dout [4];
  logic       dv   [4];
  logic       pe   [4];
  logic       fe   [4];
  logic       busy [4];

  localparam bit LSBF  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit HASP  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit ODDP  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct { int d; logic [7:0] data; logic perr; logic ferr; } exp_t;
  typedef struct { int d; logic [7:0] data; bit bad_par; bit stop; int gaps; } vec_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  vec_t       vecs  [$];
  logic [7:0] last_good [4];
  logic       prev_pulse [4];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clock = ~clock;

  serial_frame_rx #(.DATA_WIDTH(8), .SHIFT_DIRECTION("LEFT"),  .PARITY("NONE")) u_ln (
    .clock(clock), .aclr(aclr), .sclr(sclr), .enable(enable), .serial_in(sin[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(busy[0]));
  serial_frame_rx #(.DATA_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY("NONE")) u_rn (
    .clock(clock), .aclr(aclr), .sclr(sclr), .enable(enable), .serial_in(sin[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(busy[1]));
  serial_frame_rx #(.DATA_WIDTH(8), .SHIFT_DIRECTION("LEFT"),  .PARITY("EVEN")) u_le (
    .clock(clock), .aclr(aclr), .sclr(sclr), .enable(enable), .serial_in(sin[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(busy[2]));
  serial_frame_rx #(.DATA_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY("ODD")) u_ro (
    .clock(clock), .aclr(aclr), .sclr(sclr), .enable(enable), .serial_in(sin[3]),
    .data_out(dout[3]), .data_valid(dv[3]), .parity_err(pe[3]), .frame_err(fe[3]), .busy(busy[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input int d, input logic b);
    enable = 1'b1;
    sin[d] = b;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) last_good[i] = 8'h00;
  endtask

  // Builds the line bits for instance d, queues the expected outcome, then drives the frame.
  // gaps > 0 inserts enable=0 cycles after every bit, with the line inverted so a stray sample shows.
  task automatic send_frame(input int d, input logic [7:0] data, input bit bad_par,
                            input bit stop, input int gaps);
    logic bits [$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(LSBF[d] ? data[i] : data[7-i]);
    if (HASP[d]) bits.push_back((^data) ^ ODDP[d] ^ bad_par);
    bits.push_back(stop);
    e.d    = d;
    e.ferr = !stop;
    e.perr = stop & HASP[d] & bad_par;
    e.data = stop ? data : last_good[d];
    if (stop) last_good[d] = data;
    exp_q.push_back(e);
    for (int k = 0; k < bits.size(); k++) begin
      drive_bit(d, bits[k]);
      for (int g = 0; g < gaps; g++) begin
        enable = 1'b0;
        sin[d] = (k == bits.size() - 1) ? 1'b1 : ~bits[k];
        @(posedge clock);
        #1;
      end
    end
    sin[d] = 1'b1;
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (dv[i] || fe[i] || pe[i]) begin
        check($sformatf("pulse_width_%0d", i), {31'b0, prev_pulse[i]}, 32'd0);
        check($sformatf("busy_at_pulse_%0d", i), {31'b0, busy[i]}, 32'd0);
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_pulse_%0d", i), 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_instance", i, mon_e.d);
          check($sformatf("data_valid_%0d", i), {31'b0, dv[i]}, {31'b0, !mon_e.ferr});
          check($sformatf("frame_err_%0d", i), {31'b0, fe[i]}, {31'b0, mon_e.ferr});
          check($sformatf("parity_err_%0d", i), {31'b0, pe[i]}, {31'b0, mon_e.perr});
          check($sformatf("data_out_%0d", i), {24'b0, dout[i]}, {24'b0, mon_e.data});
        end
      end
      prev_pulse[i] = dv[i] | fe[i] | pe[i];
    end
  end

  initial begin
    logic seq [10];
    int   busy_cnt;
    for (int i = 0; i < 4; i++) begin
      sin[i]        = 1'b1;
      prev_pulse[i] = 1'b0;
    end
    clear_model();

    vecs.push_back('{1, 8'hA5, 1'b0, 1'b1, 0});
    vecs.push_back('{1, 8'hA5, 1'b0, 1'b1, 0});
    vecs.push_back('{1, 8'h01, 1'b0, 1'b1, 0});
    vecs.push_back('{2, 8'hA5, 1'b0, 1'b1, 0});
    vecs.push_back('{2, 8'hA5, 1'b1, 1'b1, 0});
    vecs.push_back('{0, 8'h3C, 1'b0, 1'b0, 0});
    vecs.push_back('{0, 8'h5A, 1'b0, 1'b1, 2});
    vecs.push_back('{3, 8'h3C, 1'b0, 1'b1, 0});
    vecs.push_back('{3, 8'h3C, 1'b1, 1'b1, 0});
    vecs.push_back('{3, 8'h00, 1'b0, 1'b1, 0});
    vecs.push_back('{2, 8'hFF, 1'b1, 1'b0, 0});
    vecs.push_back('{2, 8'hC3, 1'b0, 1'b1, 1});
    vecs.push_back('{1, 8'h80, 1'b0, 1'b0, 0});

    // Reset state.
    @(posedge clock);
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_data_out_%0d", i), {24'b0, dout[i]}, 32'd0);
      check($sformatf("rst_busy_%0d", i), {31'b0, busy[i]}, 32'd0);
      check($sformatf("rst_pulses_%0d", i), {29'b0, dv[i], pe[i], fe[i]}, 32'd0);
    end
    aclr = 1'b0;
    @(posedge clock);
    #1;

    // 0xA5 MSB first on continuous enable, tracking busy edge by edge.
    seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q.push_back('{0, 8'hA5, 1'b0, 1'b0});
    last_good[0] = 8'hA5;
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive_bit(0, seq[k]);
      if (busy[0]) busy_cnt++;
      if (k == 9) begin
        check("first_frame_valid", {31'b0, dv[0]}, 32'd1);
        check("first_frame_data", {24'b0, dout[0]}, 32'hA5);
      end
    end
    sin[0] = 1'b1;
    check("first_frame_busy_cycles", busy_cnt, 32'd9);

    // Table of frames, back to back.
    foreach (vecs[v]) send_frame(vecs[v].d, vecs[v].data, vecs[v].bad_par, vecs[v].stop, vecs[v].gaps);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);

    // aclr between edges after four data bits.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    sin[0] = 1'b1;
    #2;
    aclr = 1'b1;
    #1;
    check("aclr_busy", {31'b0, busy[0]}, 32'd0);
    check("aclr_data_out", {24'b0, dout[0]}, 32'd0);
    check("aclr_data_out_other", {24'b0, dout[1]}, 32'd0);
    clear_model();
    @(posedge clock);
    #3;
    aclr = 1'b0;
    @(posedge clock);
    #1;
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    drive_bit(0, 1'b1);

    // sclr with enable=1 and a start-level line: clear wins, nothing consumed.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    sclr   = 1'b1;
    enable = 1'b1;
    sin[0] = 1'b0;
    #1;
    check("sclr_before_edge_busy", {31'b0, busy[0]}, 32'd1);
    @(posedge clock);
    #1;
    sclr = 1'b0;
    check("sclr_busy", {31'b0, busy[0]}, 32'd0);
    check("sclr_data_out", {24'b0, dout[0]}, 32'd0);
    clear_model();
    drive_bit(0, 1'b1);
    check("sclr_idle_after", {31'b0, busy[0]}, 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 0);
    send_frame(3, 8'h81, 1'b1, 1'b1, 0);

    for (int k = 0; k < 4; k++) drive_bit(0, 1'b1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
